// File: rtl/i2s_tx.sv
// i2s_tx: I2S/left-justified master transmitter with internal sample FIFO
module i2s_tx #(
   parameter int FIFO_AW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [7:0]           sck_prescaler,
   input  logic [4:0]           sample_size,
   input  logic                 left_justified,
   input  logic [1:0]           channels,
   input  logic                 fifo_wr,
   input  logic [31:0]          fifo_wdata,
   input  logic [FIFO_AW:0]     fifo_level_threshold,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic [FIFO_AW:0]     fifo_level,
   output logic                 fifo_level_below,
   output logic                 underflow,
   output logic                 sck,
   output logic                 ws,
   output logic                 sdo
);
   localparam int DEPTH = 2 ** FIFO_AW;
   logic [7:0]         cnt_q, cnt_d;
   logic               sck_q, sck_d, ws_q, ws_d, sdo_q, sdo_d, lj_q, lj_d, uf_q, uf_d;
   logic [4:0]         bit_q, bit_d;
   logic [31:0]        shift_q, shift_d, load;
   logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic [31:0]        mem_q [DEPTH];
   logic               tick, fall, slot, ch_en, pop, wr_ok;
   assign fifo_full        = level_q == (FIFO_AW+1)'(DEPTH);
   assign fifo_empty       = level_q == '0;
   assign fifo_level       = level_q;
   assign fifo_level_below = level_q < fifo_level_threshold;
   assign underflow        = uf_q;
   assign sck              = sck_q;
   assign ws               = ws_q;
   assign sdo              = sdo_q;
   always_comb begin
      tick    = en && cnt_q == 8'd0;
      fall    = tick && sck_q;
      slot    = fall && bit_q == 5'd31;
      ws_d    = slot ? ~ws_q : ws_q;
      ch_en   = ws_d ? channels[0] : channels[1];
      pop     = slot && ch_en && !fifo_empty;
      wr_ok   = fifo_wr && !fifo_full;
      uf_d    = slot && ch_en && fifo_empty;
      load    = pop ? mem_q[rptr_q] << (5'd31 - sample_size) : slot ? 32'd0 : shift_q;
      cnt_d   = !en ? cnt_q : tick ? sck_prescaler : cnt_q - 8'd1;
      sck_d   = tick ? ~sck_q : sck_q;
      bit_d   = fall ? bit_q + 5'd1 : bit_q;
      shift_d = fall ? load << 1 : shift_q;
      // lj_q remembers the left-justified bit so I2S mode can lag it by one SCK
      lj_d    = fall ? load[31] : lj_q;
      sdo_d   = fall ? (left_justified ? load[31] : lj_q) : sdo_q;
      wptr_d  = wptr_q + FIFO_AW'(wr_ok);
      rptr_d  = rptr_q + FIFO_AW'(pop);
      level_d = level_q + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= sck_prescaler;
         sck_q   <= 1'b0;
         ws_q    <= 1'b1;
         sdo_q   <= 1'b0;
         lj_q    <= 1'b0;
         uf_q    <= 1'b0;
         bit_q   <= 5'd31;
         shift_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         sck_q   <= sck_d;
         ws_q    <= ws_d;
         sdo_q   <= sdo_d;
         lj_q    <= lj_d;
         uf_q    <= uf_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q] <= fifo_wdata;
   end
endmodule
